data_ram_responder: RTL and testbench

- Responder end of the word-addressed data-RAM interface driven by the memory pipeline's store/load stage: accepts word address, byte-lane write enables, write data and read enable, and returns read data one cycle later for the load-extraction stage.
- Contains the data storage array, a post-reset clear sequencer that zeroes the array, and out-of-range request detection.

---
 rtl/data_ram_responder.sv | 111 +++++++++++
 tb/tb_data_ram_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Responder end of the word-addressed data-RAM interface. Holds the data
//   array, zeroes it after every reset (when INIT_CLEAR=1), services byte-lane
//   writes and 1-cycle-latency reads, and flags out-of-range requests.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   CLEAR | writing zero to word[clr_cnt_q] each cycle, requests ignored
//   RUN   | ready_o high, requests serviced until the next reset
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   ram_addr_i   word address (byte address >> 2)
//   ram_wdata_i  lane-aligned write data
//   ram_wen_i    byte-lane write enables
//   ram_ren_i    read request
//   ram_data_o   registered read data (valid the cycle after a read)
//   ready_o      high when requests are accepted
//   err_o        one-cycle pulse: previous request was out of range
module data_ram_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = $clog2(DEPTH),
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [29:0] ram_addr_i,
    input  logic [31:0] ram_wdata_i,
    input  logic [3:0]  ram_wen_i,
    input  logic        ram_ren_i,
    output logic [31:0] ram_data_o,
    output logic        ready_o,
    output logic        err_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [31:0]     mem [DEPTH];

    logic            run;
    logic            in_range;
    logic            req;
    logic [AW-1:0]   idx;

    assign run      = (state_q == ST_RUN);
    assign in_range = (ram_addr_i[29:AW] == '0);
    assign req      = (|ram_wen_i) | ram_ren_i;
    assign idx      = ram_addr_i[AW-1:0];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
            clr_cnt_q  <= '0;
            ready_o    <= 1'b0;
            err_o      <= 1'b0;
            ram_data_o <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            // ready tracks the state being entered so it rises together with RUN
            ready_o   <= (state_d == ST_RUN);
            err_o     <= run & req & ~in_range;
            if (run && ram_ren_i) begin
                // array read sees pre-write contents: read-first on collision
                ram_data_o <= in_range ? mem[idx] : '0;
            end
        end
    end

    // Array has no reset; writes are blocked while rst_ni is low so contents
    // survive a reset untouched when INIT_CLEAR=0.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (in_range) begin
                for (int k = 0; k < 4; k++) begin
                    if (ram_wen_i[k]) begin
                        mem[idx][8*k +: 8] <= ram_wdata_i[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wen = '0;
    logic        ren = 1'b0;
    logic [31:0] data;
    logic        ready;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    data_ram_responder #(.DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ram_addr_i (addr),
        .ram_wdata_i(wdata),
        .ram_wen_i  (wen),
        .ram_ren_i  (ren),
        .ram_data_o (data),
        .ready_o    (ready),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Behavioural reference: edges since reset release decide clear vs. service.
    logic [31:0] m_mem [DEPTH];
    int          m_n;
    logic [31:0] m_data;
    logic        m_err;
    logic        m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n     <= 0;
            m_data  <= '0;
            m_err   <= 1'b0;
            m_ready <= 1'b0;
        end else if (m_n < DEPTH) begin
            m_mem[m_n] <= '0;
            m_n        <= m_n + 1;
            m_ready    <= (m_n == DEPTH - 1);
            m_err      <= 1'b0;
        end else begin
            m_ready <= 1'b1;
            m_err   <= (addr >= 30'(DEPTH)) && ((wen != 4'b0) || ren);
            if (addr < 30'(DEPTH)) begin
                for (int k = 0; k < 4; k++) begin
                    if (wen[k]) m_mem[addr[3:0]][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
            if (ren) m_data <= (addr < 30'(DEPTH)) ? m_mem[addr[3:0]] : 32'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_data", data, m_data);
            chk("model_ready", {31'b0, ready}, {31'b0, m_ready});
            chk("model_err", {31'b0, err}, {31'b0, m_err});
        end
    end

    task automatic op(input logic [29:0] a, input logic [3:0] w, input logic [31:0] d, input logic r);
        addr  = a;
        wen   = w;
        wdata = d;
        ren   = r;
        @(posedge clk);
        #1;
        addr  = '0;
        wen   = '0;
        wdata = '0;
        ren   = 1'b0;
    endtask

    task automatic idle();
        op('0, '0, '0, 1'b0);
    endtask

    // Checks ready across the whole clear window; optionally injects a write.
    task automatic clear_window(input string name, input bit poke);
        for (int k = 1; k <= DEPTH; k++) begin
            if (poke && k == 3) op(30'd2, 4'hF, 32'hFFFF_FFFF, 1'b1);
            else idle();
            chk(name, {31'b0, ready}, {31'b0, (k >= DEPTH)});
            if (k < DEPTH) chk({name, "_data"}, data, 32'h0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        rst_n = 1'b1;
        clear_window("clear_ready", 1'b1);

        // every word reads zero, including the one poked during clear
        for (int a = 0; a < DEPTH; a++) begin
            op(30'(a), 4'h0, 32'h0, 1'b1);
            chk("read_zero", data, 32'h0);
            chk("read_zero_err", {31'b0, err}, 32'h0);
        end

        // byte lanes
        op(30'd3, 4'b0001, 32'h0000_00AA, 1'b0);
        op(30'd3, 4'b0100, 32'h00CC_0000, 1'b0);
        op(30'd3, 4'b0000, 32'h0, 1'b1);
        chk("lane_a", data, 32'h00CC_00AA);
        op(30'd3, 4'b1100, 32'h1234_0000, 1'b0);
        op(30'd3, 4'b0000, 32'h0, 1'b1);
        chk("lane_b", data, 32'h1234_00AA);

        // read-first collision
        op(30'd5, 4'hF, 32'h1111_1111, 1'b0);
        op(30'd5, 4'hF, 32'h2222_2222, 1'b1);
        chk("collide_old", data, 32'h1111_1111);
        op(30'd5, 4'h0, 32'h0, 1'b1);
        chk("collide_new", data, 32'h2222_2222);

        // out of range
        op(30'd16, 4'h0, 32'h0, 1'b1);
        chk("oor_rd_data", data, 32'h0);
        chk("oor_rd_err", {31'b0, err}, 32'h1);
        idle();
        chk("oor_err_pulse", {31'b0, err}, 32'h0);
        op(30'h20, 4'hF, 32'hDEAD_BEEF, 1'b0);
        chk("oor_wr_err", {31'b0, err}, 32'h1);
        op(30'd0, 4'h0, 32'h0, 1'b1);
        chk("oor_wr_word0", data, 32'h0);
        chk("oor_wr_err_clr", {31'b0, err}, 32'h0);

        // back-to-back reads then hold
        op(30'd1, 4'hF, 32'hA, 1'b0);
        op(30'd2, 4'hF, 32'hB, 1'b0);
        op(30'd3, 4'hF, 32'hC, 1'b0);
        op(30'd1, 4'h0, 32'h0, 1'b1);
        chk("b2b_a", data, 32'hA);
        op(30'd2, 4'h0, 32'h0, 1'b1);
        chk("b2b_b", data, 32'hB);
        op(30'd3, 4'h0, 32'h0, 1'b1);
        chk("b2b_c", data, 32'hC);
        idle();
        chk("hold_1", data, 32'hC);
        idle();
        chk("hold_2", data, 32'hC);

        // randomized traffic, including out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            op(30'($urandom_range(0, DEPTH + 3)),
               ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
               $urandom, 1'($urandom_range(0, 1)));
        end

        // reset mid-run, then mid-clear
        op(30'd4, 4'hF, 32'h5555_5555, 1'b0);
        op(30'd4, 4'h0, 32'h0, 1'b1);
        chk("pre_rst_word", data, 32'h5555_5555);
        rst_n = 1'b0;
        #1;
        chk("run_rst_data", data, 32'h0);
        chk("run_rst_ready", {31'b0, ready}, 32'h0);
        repeat (2) idle();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            idle();
            chk("mid_clear_ready", {31'b0, ready}, 32'h0);
        end
        rst_n = 1'b0;
        repeat (2) idle();
        chk("mid_clear_rst_ready", {31'b0, ready}, 32'h0);
        rst_n = 1'b1;
        clear_window("reclear_ready", 1'b0);
        op(30'd4, 4'h0, 32'h0, 1'b1);
        chk("post_clear_word", data, 32'h0);
        for (int i = 0; i < 100; i++) begin
            op(30'($urandom_range(0, DEPTH + 3)), 4'($urandom_range(0, 15)),
               $urandom, 1'($urandom_range(0, 1)));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
